// File: rtl/ball_motion.sv
// Breakout ball-position engine: steps the ball once per movement tick, bouncing off
// walls, the paddle and bricks, and flags a ball that drops past the paddle.
module ball_motion #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 8,
  parameter int STEP      = 2,
  parameter int PADDLE_W  = 64,
  parameter int PADDLE_Y  = 440,
  parameter int X_INIT    = 316,
  parameter int Y_INIT    = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulse,
  input  logic       launch,
  input  logic       brick_hit,
  input  logic [9:0] paddle_x,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       moving,
  output logic       ball_lost,
  output logic [1:0] dbg_state
);

  // Handshake: pulse, launch and brick_hit are single-cycle strobes with no
  // back-pressure; each is acted on in the cycle it is high, results appear next cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    LOST = 2'd2
  } state_t;

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BS_W   = 11'(BALL_SIZE);
  localparam logic [10:0] PW_W   = 11'(PADDLE_W);
  localparam logic [10:0] PY_W   = 11'(PADDLE_Y);
  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - BALL_SIZE);

  state_t state;
  logic   dir_x_right;
  logic   dir_y_down;
  logic   hit_pend;

  logic [10:0] x11, y11, px11;
  logic        dy_down_eff;
  logic [9:0]  nx, ny;
  logic        ndir_x, ndir_y, lost_now;

  assign dbg_state = state;
  assign x11  = {1'b0, ball_x};
  assign y11  = {1'b0, ball_y};
  assign px11 = {1'b0, paddle_x};

  // Next position for a tick in MOVE; all comparisons at 11 bits to avoid wrap.
  always_comb begin
    dy_down_eff = dir_y_down ^ (hit_pend | brick_hit);
    nx       = ball_x;
    ny       = ball_y;
    ndir_x   = dir_x_right;
    ndir_y   = dy_down_eff;
    lost_now = 1'b0;

    if (!dir_x_right) begin
      if (x11 < STEP_W) begin
        nx     = 10'd0;
        ndir_x = 1'b1;
      end else begin
        nx = 10'(x11 - STEP_W);
      end
    end else if (x11 + STEP_W > X_MAX) begin
      nx     = 10'(X_MAX);
      ndir_x = 1'b0;
    end else begin
      nx = 10'(x11 + STEP_W);
    end

    if (!dy_down_eff) begin
      if (y11 < STEP_W) begin
        ny     = 10'd0;
        ndir_y = 1'b1;
      end else begin
        ny = 10'(y11 - STEP_W);
      end
    end else if ((y11 + BS_W + STEP_W >= PY_W) && (y11 + BS_W <= PY_W) &&
                 (x11 + BS_W > px11) && (x11 < px11 + PW_W)) begin
      ny     = 10'(PY_W - BS_W);
      ndir_y = 1'b0;
    end else if (y11 + STEP_W >= Y_MAX) begin
      lost_now = 1'b1;
      nx       = ball_x;
      ny       = ball_y;
    end else begin
      ny = 10'(y11 + STEP_W);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ball_x      <= 10'(X_INIT);
      ball_y      <= 10'(Y_INIT);
      dir_x_right <= 1'b1;
      dir_y_down  <= 1'b0;
      moving      <= 1'b0;
      ball_lost   <= 1'b0;
      hit_pend    <= 1'b0;
    end else begin
      ball_lost <= 1'b0;
      case (state)
        IDLE: begin
          hit_pend <= 1'b0;
          if (launch) begin
            state       <= MOVE;
            moving      <= 1'b1;
            dir_x_right <= 1'b1;
            dir_y_down  <= 1'b0;
          end
        end
        MOVE: begin
          if (pulse) begin
            hit_pend <= 1'b0;
            if (lost_now) begin
              state     <= LOST;
              moving    <= 1'b0;
              ball_lost <= 1'b1;
            end else begin
              ball_x      <= nx;
              ball_y      <= ny;
              dir_x_right <= ndir_x;
              dir_y_down  <= ndir_y;
            end
          end else if (brick_hit) begin
            hit_pend <= 1'b1;
          end
        end
        LOST: begin
          hit_pend <= 1'b0;
          if (launch) begin
            state       <= IDLE;
            ball_x      <= 10'(X_INIT);
            ball_y      <= 10'(Y_INIT);
            dir_x_right <= 1'b1;
            dir_y_down  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: a behavioural ball model feeds an expected queue that is
// checked one cycle after every tick/launch, plus fixed-value checks at key points.
module tb_ball_motion;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pulse = 1'b0;
  logic       launch = 1'b0;
  logic       brick_hit = 1'b0;
  logic [9:0] paddle_x = 10'd0;
  logic [9:0] ball_x, ball_y;
  logic       moving, ball_lost;
  logic [1:0] dbg_state;

  ball_motion dut (
    .clock(clock), .reset(reset), .pulse(pulse), .launch(launch),
    .brick_hit(brick_hit), .paddle_x(paddle_x), .ball_x(ball_x), .ball_y(ball_y),
    .moving(moving), .ball_lost(ball_lost), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // {state, ball_lost, moving, x, y}
  logic [23:0] obs;
  assign obs = {dbg_state, ball_lost, moving, ball_x, ball_y};

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_v;

  int m_x, m_y, m_dx, m_dy, m_state;
  bit m_pend, m_lost;
  int fixed_pad = 200;

  function automatic logic [23:0] model_pack();
    logic mv;
    mv = (m_state == 1);
    return {2'(m_state), m_lost, mv, 10'(m_x), 10'(m_y)};
  endfunction

  task automatic model_reset();
    m_x = 316; m_y = 300; m_dx = 1; m_dy = -1; m_state = 0;
    m_pend = 0; m_lost = 0;
  endtask

  task automatic model_pulse(input bit brick, input int pad);
    int dy, nx, ny, ndx, ndy;
    bit lost;
    if (m_state != 1) begin
      m_pend = 0;
      return;
    end
    dy = (m_pend || brick) ? -m_dy : m_dy;
    m_pend = 0;
    ndx = m_dx; ndy = dy; lost = 0;
    nx = m_x + 2 * m_dx;
    if (nx < 0) begin nx = 0; ndx = 1; end
    else if (nx > 632) begin nx = 632; ndx = -1; end
    if (dy < 0) begin
      ny = m_y - 2;
      if (ny < 0) begin ny = 0; ndy = 1; end
    end else if (m_y + 10 >= 440 && m_y + 8 <= 440 && m_x + 8 > pad && m_x < pad + 64) begin
      ny = 432; ndy = -1;
    end else if (m_y + 2 >= 472) begin
      lost = 1; ny = m_y;
    end else begin
      ny = m_y + 2;
    end
    if (lost) begin
      m_state = 2; m_lost = 1;
    end else begin
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    end
  endtask

  task automatic drive_pulse(input bit brick);
    @(negedge clock);
    paddle_x = (fixed_pad >= 0) ? 10'(fixed_pad) : ((m_x >= 320) ? 10'd0 : 10'd560);
    pulse = 1'b1;
    brick_hit = brick;
    model_pulse(brick, int'(paddle_x));
    exp_q.push_back(model_pack());
    m_lost = 0;
    @(negedge clock);
    pulse = 1'b0;
    brick_hit = 1'b0;
  endtask

  task automatic drive_launch();
    @(negedge clock);
    launch = 1'b1;
    if (m_state == 0) begin
      m_state = 1; m_dx = 1; m_dy = -1;
    end else if (m_state == 2) begin
      m_state = 0; m_x = 316; m_y = 300; m_dx = 1; m_dy = -1;
    end
    m_pend = 0;
    exp_q.push_back(model_pack());
    @(negedge clock);
    launch = 1'b0;
  endtask

  task automatic drive_brick_only();
    @(negedge clock);
    brick_hit = 1'b1;
    if (m_state == 1) m_pend = 1;
    @(negedge clock);
    brick_hit = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    checks++;
    if (obs !== {2'd0, 1'b0, 1'b0, 10'd316, 10'd300}) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs, {2'd0, 2'b00, 10'd316, 10'd300});
    end
  endtask

  task automatic test_idle_pulse();
    for (int i = 0; i < 3; i++) begin
      drive_pulse(0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL idle_pulse%0d got=%h exp=%h", i, obs, exp_v); end
    end
    checks++;
    if (ball_x !== 10'd316 || ball_y !== 10'd300 || moving !== 1'b0) begin
      failures++; $display("FAIL idle_hold got=(%0d,%0d,%b) exp=(316,300,0)", ball_x, ball_y, moving);
    end
  endtask

  task automatic test_serve();
    drive_launch();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL serve_launch got=%h exp=%h", obs, exp_v); end
    for (int i = 1; i <= 10; i++) begin
      drive_pulse(0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL serve_step%0d got=%h exp=%h", i, obs, exp_v); end
    end
    checks++;
    if (ball_x !== 10'd336 || ball_y !== 10'd280 || moving !== 1'b1) begin
      failures++; $display("FAIL serve_pos got=(%0d,%0d,%b) exp=(336,280,1)", ball_x, ball_y, moving);
    end
    drive_launch();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL launch_in_move got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_walls();
    for (int n = 11; n <= 160; n++) begin
      drive_pulse(0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL wall_step%0d got=%h exp=%h", n, obs, exp_v); end
      if (n == 151) begin
        checks++;
        if (ball_y !== 10'd0) begin failures++; $display("FAIL top_wall got=%0d exp=0", ball_y); end
      end
      if (n == 158 || n == 159) begin
        checks++;
        if (ball_x !== 10'd632) begin failures++; $display("FAIL right_wall%0d got=%0d exp=632", n, ball_x); end
      end
      if (n == 160) begin
        checks++;
        if (ball_x !== 10'd630) begin failures++; $display("FAIL right_rebound got=%0d exp=630", ball_x); end
      end
    end
  endtask

  task automatic test_paddle();
    for (int n = 161; n <= 368; n++) begin
      drive_pulse(0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL paddle_step%0d got=%h exp=%h", n, obs, exp_v); end
      if (n == 367) begin
        checks++;
        if (ball_y !== 10'd432) begin failures++; $display("FAIL paddle_snap got=%0d exp=432", ball_y); end
      end
    end
    checks++;
    if (ball_y !== 10'd430) begin failures++; $display("FAIL paddle_rebound got=%0d exp=430", ball_y); end
  endtask

  task automatic test_brick();
    fixed_pad = -1;
    drive_brick_only();
    drive_brick_only();
    drive_pulse(0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL brick_double got=%h exp=%h", obs, exp_v); end
    checks++;
    if (ball_y !== 10'd432) begin failures++; $display("FAIL brick_single_inv got=%0d exp=432", ball_y); end
    drive_pulse(1);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL brick_same_cycle got=%h exp=%h", obs, exp_v); end
    checks++;
    if (ball_y !== 10'd430) begin failures++; $display("FAIL brick_same_y got=%0d exp=430", ball_y); end
    drive_brick_only();
    drive_pulse(0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL brick_pend got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_lost();
    logic [9:0] fx, fy;
    int budget;
    budget = 0;
    while (m_state == 1 && budget < 60) begin
      drive_pulse(0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL lost_step%0d got=%h exp=%h", budget, obs, exp_v); end
      budget++;
    end
    checks++;
    if (m_state != 2 || ball_lost !== 1'b1) begin
      failures++; $display("FAIL lost_reached got=%b exp=1 after %0d ticks", ball_lost, budget);
    end
    fx = ball_x; fy = ball_y;
    @(negedge clock);
    checks++;
    if (ball_lost !== 1'b0 || dbg_state !== 2'd2 || moving !== 1'b0) begin
      failures++; $display("FAIL lost_one_cycle got=(%b,%0d,%b) exp=(0,2,0)", ball_lost, dbg_state, moving);
    end
    drive_brick_only();
    drive_pulse(1);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || ball_x !== fx || ball_y !== fy) begin
      failures++; $display("FAIL lost_hold got=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_relaunch();
    drive_launch();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || obs !== {2'd0, 1'b0, 1'b0, 10'd316, 10'd300}) begin
      failures++; $display("FAIL relaunch_idle got=%h exp=%h", obs, exp_v);
    end
    drive_launch();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL relaunch_move got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_move();
    for (int i = 0; i < 42; i++) begin
      drive_pulse(0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL mid_step%0d got=%h exp=%h", i, obs, exp_v); end
    end
    @(negedge clock);
    reset = 1'b1;
    pulse = 1'b1;
    launch = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    pulse = 1'b0;
    launch = 1'b0;
    model_reset();
    checks++;
    if (obs !== {2'd0, 1'b0, 1'b0, 10'd316, 10'd300}) begin
      failures++; $display("FAIL reset_mid_move got=%h exp=%h", obs, {2'd0, 2'b00, 10'd316, 10'd300});
    end
  endtask

  initial begin
    test_reset();
    test_idle_pulse();
    test_serve();
    test_walls();
    test_paddle();
    test_brick();
    test_lost();
    test_relaunch();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
